// File: rtl/multi_debouncer.sv
// multi_debouncer: CHANNELS independent debouncers, one FSM + counter per lane.
//   A channel asserts after PRESS_CYCLES consecutive high samples and deasserts
//   after RELEASE_CYCLES consecutive low samples. Any contrary sample during
//   qualification aborts it and the next attempt starts a fresh count.
//
// Optional macro: DEBOUNCE_SYNC_EN -- when defined, a 2-flop synchronizer per
//   channel sits ahead of the FSMs (adds 2 cycles of latency). When undefined,
//   noisy must already be synchronous to clk.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high
//   noisy     in   [CHANNELS] raw inputs
//   debounce  out  [CHANNELS] debounced level (STABLE_HIGH or WAIT_LOW)
//   rise      out  [CHANNELS] one-cycle pulse, first cycle debounce is 1
//   fall      out  [CHANNELS] one-cycle pulse, first cycle debounce is 0 again
//   busy      out  [CHANNELS] channel is qualifying a change

// Per-channel FSM and counter.
module debounce_lane #(
  parameter int PRESS_CYCLES   = 16,
  parameter int RELEASE_CYCLES = 16,
  parameter int CW             = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic debounce,
  output logic rise,
  output logic fall,
  output logic busy
);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_t;

  localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, fall_q;
  logic          deb_q, deb_d;

  // Every state exit clears the counter, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE_LOW: if (din) begin
        state_d = WAIT_HIGH;
        cnt_d   = '0;
      end
      WAIT_HIGH: begin
        if (!din) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == PRESS_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HIGH: if (!din) begin
        state_d = WAIT_LOW;
        cnt_d   = '0;
      end
      WAIT_LOW: begin
        if (din) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign deb_q = (state_q == STABLE_HIGH) || (state_q == WAIT_LOW);
  assign deb_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);

  // Edge pulses are registered alongside the state so they line up with the
  // first cycle of the new debounce level. Reset forces IDLE_LOW without
  // producing a fall pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= deb_d & ~deb_q;
      fall_q  <= deb_q & ~deb_d;
    end
  end

  assign debounce = deb_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign busy     = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
endmodule

module multi_debouncer #(
  parameter int CHANNELS       = 4,
  parameter int PRESS_CYCLES   = 16,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounce,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] busy
);
  localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(MAXC);

  logic [CHANNELS-1:0] fsm_in;

`ifdef DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
    end
  end
  assign fsm_in = sync2;
`else
  assign fsm_in = noisy;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    debounce_lane #(
      .PRESS_CYCLES  (PRESS_CYCLES),
      .RELEASE_CYCLES(RELEASE_CYCLES),
      .CW            (CW)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .din     (fsm_in[g]),
      .debounce(debounce[g]),
      .rise    (rise[g]),
      .fall    (fall[g]),
      .busy    (busy[g])
    );
  end
endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer (CHANNELS=4, PRESS=RELEASE=8).
// Edge j counts from the first edge that samples a new noisy value; a change
// shows up after edge 9+L (L = 2 when DEBOUNCE_SYNC_EN is defined).
module tb_multi_debouncer;
  localparam int CH = 4;
  localparam int N  = 8;
`ifdef DEBOUNCE_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif
  localparam int D = N + 1 + L;  // edge index at which debounce changes

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy;
  logic [CH-1:0] debounce, rise, fall, busy;

  int n_cmp = 0;
  int n_err = 0;

  multi_debouncer #(.CHANNELS(CH), .PRESS_CYCLES(N), .RELEASE_CYCLES(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .noisy   (noisy),
    .debounce(debounce),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    reset = 1'b1;
    noisy = '0;
    tick();
    tick();
    chk("rst_deb",  32'(debounce), 32'h0);
    chk("rst_rise", 32'(rise),     32'h0);
    chk("rst_fall", 32'(fall),     32'h0);
    chk("rst_busy", 32'(busy),     32'h0);
    reset = 1'b0;
    tick();

    // Clean press on channel 0.
    noisy[0] = 1'b1;
    for (int j = 1; j <= D + 1; j++) begin
      tick();
      chk("p0_deb",  32'(debounce[0]), 32'(j >= D));
      chk("p0_rise", 32'(rise[0]),     32'(j == D));
      chk("p0_busy", 32'(busy[0]),     32'(j >= 1 + L && j <= N + L));
    end

    // Channel 1 high for 7 samples: too short, nothing happens.
    for (int j = 1; j <= D + 4; j++) begin
      noisy[1] = (j <= 7);
      tick();
      chk("short1_out", 32'({debounce[1], rise[1], fall[1]}), 32'h0);
    end

    // Channel 1 high 8 samples, glitch low on the final qualifying edge,
    // then high again: full count restarts from edge 10.
    for (int j = 1; j <= D + 10; j++) begin
      noisy[1] = (j <= 8) || (j >= 10);
      tick();
      chk("glitch1_deb",  32'(debounce[1]), 32'(j >= D + 9));
      chk("glitch1_rise", 32'(rise[1]),     32'(j == D + 9));
      chk("glitch1_fall", 32'(fall[1]),     32'h0);
    end

    // Channel 2: debounce high, then bounce 0(3) 1(3) 0(hold).
    noisy[2] = 1'b1;
    for (int j = 1; j <= D + 1; j++) tick();
    chk("b2_pre_deb", 32'(debounce[2]), 32'h1);
    for (int t = 1; t <= D + 8; t++) begin
      noisy[2] = (t >= 4 && t <= 6);
      tick();
      chk("b2_fall", 32'(fall[2]),     32'(t == D + 6));
      chk("b2_deb",  32'(debounce[2]), 32'(t < D + 6));
      chk("b2_rise", 32'(rise[2]),     32'h0);
    end

    // Release everything: channels 0 and 1 fall together.
    noisy = '0;
    for (int j = 1; j <= D + 1; j++) begin
      tick();
      chk("rel_fall", 32'(fall),     (j == D) ? 32'h3 : 32'h0);
      chk("rel_deb",  32'(debounce), (j >= D) ? 32'h0 : 32'h3);
    end

    // All four channels pressed at once.
    noisy = 4'b1111;
    for (int j = 1; j <= D + 1; j++) begin
      tick();
      chk("all_rise", 32'(rise),     (j == D) ? 32'hf : 32'h0);
      chk("all_deb",  32'(debounce), (j >= D) ? 32'hf : 32'h0);
    end

    // Reset while stable high and input held: no fall, full re-qualify.
    reset = 1'b1;
    tick();
    chk("mrst_deb",  32'(debounce), 32'h0);
    chk("mrst_rise", 32'(rise),     32'h0);
    chk("mrst_fall", 32'(fall),     32'h0);
    chk("mrst_busy", 32'(busy),     32'h0);
    reset = 1'b0;
    for (int j = 1; j <= D + 1; j++) begin
      tick();
      chk("post_fall",  32'(fall),        32'h0);
      chk("post_deb3",  32'(debounce[3]), 32'(j >= D));
      chk("post_rise3", 32'(rise[3]),     32'(j == D));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent inputs (legal range 1..32).
REQ-002 The block SHALL have parameter PRESS_CYCLES, default 16, giving the stable-high time required to assert a channel (legal range 2..65535).
REQ-003 The block SHALL have parameter RELEASE_CYCLES, default 16, giving the stable-low time required to deassert a channel (legal range 2..65535).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; one clock, reset is synchronous and active-high.
REQ-006 The block SHALL have port noisy, input, CHANNELS bits, the raw bouncing inputs, one bit per channel.
REQ-007 The block SHALL have port debounce, output, CHANNELS bits, the registered debounced level per channel.
REQ-008 The block SHALL have port rise, output, CHANNELS bits, a one-cycle pulse when the matching debounce bit goes 0->1.
REQ-009 The block SHALL have port fall, output, CHANNELS bits, a one-cycle pulse when the matching debounce bit goes 1->0.
REQ-010 The block SHALL have port busy, output, CHANNELS bits, high while a channel is qualifying a change (WAIT_HIGH or WAIT_LOW).

Function
REQ-011 Each channel SHALL use a private 4-state FSM (IDLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW) and a private counter of width clog2(max(PRESS_CYCLES,RELEASE_CYCLES)); no external timer exists.
REQ-012 IDLE_LOW: a sampled input of 1 SHALL go to WAIT_HIGH with the counter cleared to 0; otherwise the FSM SHALL stay.
REQ-013 WAIT_HIGH: a sampled input of 0 SHALL return to IDLE_LOW and clear the counter. At count == PRESS_CYCLES-1 with input 1, the FSM SHALL go to STABLE_HIGH. Otherwise the counter SHALL increment.
REQ-014 STABLE_HIGH: a sampled input of 0 SHALL go to WAIT_LOW with the counter cleared; otherwise the FSM SHALL stay.
REQ-015 WAIT_LOW: a sampled input of 1 SHALL return to STABLE_HIGH and clear the counter. At count == RELEASE_CYCLES-1 with input 0, the FSM SHALL go to IDLE_LOW. Otherwise the counter SHALL increment.
REQ-016 debounce SHALL be 1 exactly in STABLE_HIGH and WAIT_LOW.
REQ-017 busy SHALL be 1 exactly in WAIT_HIGH and WAIT_LOW.
REQ-018 rise SHALL be registered and SHALL be high for exactly one cycle, in the first cycle debounce is 1. fall SHALL follow the same rule for the first cycle debounce is 0 after being 1.
REQ-019 Latency: with a steady input change first sampled at edge k, debounce SHALL change at edge k+PRESS_CYCLES (rising) or k+RELEASE_CYCLES (falling).
REQ-020 A glitch sampled on the final qualifying edge (count == N-1, input reverted) SHALL abort the change. No pulse SHALL be produced, and a later attempt SHALL restart the full count.
REQ-021 Channels SHALL be fully independent. Simultaneous changes on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 The counter SHALL never wrap. It saturates by construction because it is cleared on every state exit.

Reset
REQ-023 While reset is 1 at a clk edge, every channel SHALL enter IDLE_LOW, counters SHALL be 0, and debounce, rise, fall and busy SHALL be 0 (synchronizer flops, if present, also 0).
REQ-024 Reset asserted mid-qualification or in STABLE_HIGH SHALL discard progress without emitting fall. After release, a held-high input SHALL need the full PRESS_CYCLES again.

Configuration
REQ-025 Macro DEBOUNCE_SYNC_EN, when defined, SHALL insert a 2-flop synchronizer per channel ahead of the FSM. This adds exactly 2 cycles to every latency in REQ-019.
REQ-026 When DEBOUNCE_SYNC_EN is undefined, the FSM SHALL sample noisy directly. The caller then guarantees noisy is synchronous to clk.

Verification (CHANNELS=4, PRESS_CYCLES=RELEASE_CYCLES=8, macro undefined unless stated)
REQ-027 noisy[0] steps 0->1 and holds -> debounce[0]=1 and rise[0]=1 (one cycle) 8 edges after the first sampled 1, with busy[0]=1 for those 8 cycles.
REQ-028 noisy[1] high for 7 cycles then low -> debounce[1], rise[1] and fall[1] stay 0 throughout.
REQ-029 noisy[2] debounced high, then bounces 1-0-1-0 with 3-cycle gaps, then holds 0 -> single fall[2] pulse 8 edges after the final 0 sample.
REQ-030 noisy = 4'b1111 at one edge and held -> rise = 4'b1111 in the same single cycle.
REQ-031 reset pulsed while debounce[3]=1 and noisy[3]=1 -> outputs 0 with no fall; after release debounce[3] rises 8 edges later.
REQ-032 DEBOUNCE_SYNC_EN defined, repeat REQ-027 -> debounce[0] rises 10 edges after noisy[0] changes.
